mem_wb_pipe: RTL and testbench
==============================

// Module: mem_wb_pipe
// PURPOSE
//  Downstream end of the EX-stage forwarding interface. Registers EX results into EX/MEM.
//  Performs the data-memory access over a req/ack handshake, then registers into MEM/WB.
//  Drives the forwarding sources that EX consumes:
//    ALUResult_mem, rdAddr_mem, RegWrite_mem, RegWriteData_wb, rdAddr_wb, RegWrite_wb.
//  Raises mem_stall while a memory access is outstanding.
// PARAMETERS
//  None. Datapath is fixed at 32-bit RV32I; register addresses are 5 bits.
// PORTS
//  clk              in   1   clock; all state updates on the rising edge
//  reset            in   1   synchronous, active-high
//  ALUResult_ex     in   32  ALU result; also the effective address for loads/stores
//  MemWriteData_ex  in   32  store data, already forwarded
//  rdAddr_ex        in   5   destination register
//  RegWrite_ex      in   1   instruction writes rd
//  MemRead_ex       in   1   load
//  MemWrite_ex      in   1   store
//  MemtoReg_ex      in   1   writeback selects load data instead of ALU result
//  funct3_ex        in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  flush_ex         in   1   insert a bubble into EX/MEM
//  dmem_req         out  1   access request
//  dmem_we          out  1   1 = write
//  dmem_addr        out  32  {addr[31:2],2'b00}
//  dmem_be          out  4   byte-lane enables
//  dmem_wdata       out  32  lane-aligned store data
//  dmem_ack         in   1   access complete; dmem_rdata valid in the same cycle
//  dmem_rdata       in   32  read word
//  ALUResult_mem    out  32  EX/MEM ALU result
//  rdAddr_mem       out  5   EX/MEM rd
//  RegWrite_mem     out  1   EX/MEM write enable
//  RegWriteData_wb  out 32  MEM/WB writeback data
//  rdAddr_wb        out  5   MEM/WB rd
//  RegWrite_wb      out  1   MEM/WB write enable
//  mem_stall        out  1   upstream must hold PC, IF/ID and ID/EX
//  misalign_mem     out  1   misaligned access flag; see CONFIGURATION
// BEHAVIOUR
//  Reset: every output and every pipeline register is 0; FSM goes to IDLE.
//   A reset during WAIT abandons the access; dmem_req is low the following cycle.
//  EX/MEM loads on each edge when !mem_stall; the bubble forces RegWrite, MemRead, MemWrite to 0.
//   With flush_ex=1, EX/MEM captures a bubble. While mem_stall=1, EX/MEM holds and flush_ex is ignored.
//  memop = EX/MEM MemRead | MemWrite. FSM:
//   IDLE: dmem_req = memop. If memop & !ack -> WAIT.
//   WAIT: dmem_req=1, with address, byte enables and data held. On ack -> IDLE.
//  mem_stall = memop & !dmem_ack, in both states. A single-cycle ack produces no stall.
//  MEM/WB loads every cycle. While mem_stall=1 it loads a bubble (RegWrite_wb=0).
//  Latency: non-memory op EX->WB is 2 edges. A memory op is 2 edges plus the wait cycles.
//  Store lanes, using a = addr[1:0]:
//   SB: be = 4'b0001<<a; wdata = byte replicated x4.
//   SH: be = a[1] ? 1100 : 0011; wdata = halfword replicated x2.
//   SW: be = 1111.
//   Loads: dmem_be = 1111, dmem_we = 0.
//  Load extract: select the byte/half by a, then sign-extend (B, H) or zero-extend (BU, HU).
//   The result is latched into RegWriteData_wb on the ack edge.
//  RegWriteData_wb = MemtoReg ? extracted load data : ALUResult.
//  Load-use hazards are not resolved here; the upstream hazard unit inserts that bubble.
//   RegWrite_mem is asserted for loads, so the hazard unit must stall dependants.
//  rd=0 is passed through unchanged; consumers qualify on rd!=0.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined:
//   H/HU/SH with a[0]=1, or W/SW with a!=0, is treated as a fault. For that access:
//   no dmem_req, no stall, RegWrite_wb=0 for it, and misalign_mem=1 for exactly 1 cycle (EX/MEM cycle).
//  Not defined: misalign_mem is tied 0. Low address bits are truncated:
//   H ignores a[0]; W ignores a[1:0].
// TESTING
//  1. After reset, add x5 with result 0x10, no mem -> edge1 rdAddr_mem=5, RegWrite_mem=1;
//     edge2 RegWriteData_wb=0x10, RegWrite_wb=1.
//  2. SB at addr 0x103, data 0xAB, ack same cycle -> dmem_be=1000, dmem_wdata=0xABABABAB,
//     dmem_addr=0x100, mem_stall never asserted.
//  3. LB at addr 0x2, rdata 0x0080_0000, ack 3 cycles late -> mem_stall high 3 cycles,
//     RegWrite_wb=0 during those cycles, then RegWriteData_wb=0xFFFFFF80.
//     Repeat as LBU -> 0x00000080.
//  4. Back-to-back LW then add, ack 1 cycle late -> EX/MEM holds the add;
//     the add reaches WB exactly 1 cycle after the load.
//  5. Reset asserted in WAIT -> next cycle dmem_req=0, all outputs 0, state IDLE;
//     flush_ex while stalled -> EX/MEM unchanged.
//  6. MEM_MISALIGN_CHECK_EN defined, LW at 0x6 -> no dmem_req, misalign_mem=1 for 1 cycle,
//     RegWrite_wb=0. Not defined -> dmem_addr=0x4, be=1111.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with a req/ack data-memory access FSM.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (misaligned accesses become faults).
module mem_wb_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic [2:0]  funct3_ex,
  input  logic        flush_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        mem_stall,
  output logic        misalign_mem
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] alu_r, store_data_r, wb_data_r;
  logic [4:0]  rd_r, rd_wb_r;
  logic [2:0]  funct3_r;
  logic        regwrite_r, memread_r, memwrite_r, memtoreg_r, misalign_r, regwrite_wb_r;
  logic        memop_s, mem_stall_s, dmem_req_s, misalign_ex_s;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'd0, b};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = w;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = a[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  assign misalign_ex_s = (MemRead_ex | MemWrite_ex) & ~flush_ex &
                         is_misaligned(funct3_ex[1:0], ALUResult_ex[1:0]);
`else
  assign misalign_ex_s = 1'b0;
`endif

  assign memop_s     = memread_r | memwrite_r;
  assign mem_stall_s = memop_s & ~dmem_ack;

  // EX/MEM register: a faulted access enters as a bubble with only the fault flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_r <= 32'd0;  store_data_r <= 32'd0;  rd_r <= 5'd0;  funct3_r <= 3'd0;
      regwrite_r <= 1'b0;  memread_r <= 1'b0;  memwrite_r <= 1'b0;
      memtoreg_r <= 1'b0;  misalign_r <= 1'b0;
    end else if (!mem_stall_s) begin
      alu_r        <= ALUResult_ex;
      store_data_r <= MemWriteData_ex;
      rd_r         <= rdAddr_ex;
      funct3_r     <= funct3_ex;
      memtoreg_r   <= MemtoReg_ex;
      misalign_r   <= misalign_ex_s;
      if (flush_ex || misalign_ex_s) begin
        regwrite_r <= 1'b0;  memread_r <= 1'b0;  memwrite_r <= 1'b0;
      end else begin
        regwrite_r <= RegWrite_ex;  memread_r <= MemRead_ex;  memwrite_r <= MemWrite_ex;
      end
    end
  end

  // Access FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Access FSM next state and request
  always_comb begin
    state_nxt_s = state_r;
    dmem_req_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        dmem_req_s = memop_s;
        if (memop_s && !dmem_ack) state_nxt_s = ST_WAIT;
        else                      state_nxt_s = ST_IDLE;
      end
      ST_WAIT: begin
        dmem_req_s = 1'b1;
        if (dmem_ack) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_WAIT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        dmem_req_s  = 1'b0;
      end
    endcase
  end

  // MEM/WB register: a stalled cycle retires nothing; load data is captured on the ack edge
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data_r <= 32'd0;  rd_wb_r <= 5'd0;  regwrite_wb_r <= 1'b0;
    end else if (mem_stall_s) begin
      regwrite_wb_r <= 1'b0;
    end else begin
      regwrite_wb_r <= regwrite_r;
      rd_wb_r       <= rd_r;
      wb_data_r     <= (memtoreg_r && memread_r) ?
                       load_extract(funct3_r, alu_r[1:0], dmem_rdata) : alu_r;
    end
  end

  assign dmem_req        = dmem_req_s;
  assign dmem_we         = memwrite_r;
  assign dmem_addr       = memop_s ? {alu_r[31:2], 2'b00} : 32'd0;
  assign dmem_be         = memwrite_r ? store_be(funct3_r[1:0], alu_r[1:0]) :
                           (memread_r ? 4'b1111 : 4'b0000);
  assign dmem_wdata      = memwrite_r ? store_lanes(funct3_r[1:0], store_data_r) : 32'd0;
  assign ALUResult_mem   = alu_r;
  assign rdAddr_mem      = rd_r;
  assign RegWrite_mem    = regwrite_r;
  assign RegWriteData_wb = wb_data_r;
  assign rdAddr_wb       = rd_wb_r;
  assign RegWrite_wb     = regwrite_wb_r;
  assign mem_stall       = mem_stall_s;
  assign misalign_mem    = misalign_r;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe; writeback results are checked against a scoreboard queue.
module tb_mem_wb_pipe;

  logic        clk, reset;
  logic [31:0] ALUResult_ex, MemWriteData_ex, dmem_rdata;
  logic [4:0]  rdAddr_ex;
  logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, flush_ex, dmem_ack;
  logic [2:0]  funct3_ex;
  logic        dmem_req, dmem_we, RegWrite_mem, RegWrite_wb, mem_stall, misalign_mem;
  logic [31:0] dmem_addr, dmem_wdata, ALUResult_mem, RegWriteData_wb;
  logic [3:0]  dmem_be;
  logic [4:0]  rdAddr_mem, rdAddr_wb;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  mem_wb_pipe dut (
    .clk(clk), .reset(reset),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex), .rdAddr_ex(rdAddr_ex),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemtoReg_ex(MemtoReg_ex), .funct3_ex(funct3_ex), .flush_ex(flush_ex),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem), .RegWrite_mem(RegWrite_mem),
    .RegWriteData_wb(RegWriteData_wb), .rdAddr_wb(rdAddr_wb), .RegWrite_wb(RegWrite_wb),
    .mem_stall(mem_stall), .misalign_mem(misalign_mem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ALUResult_ex = 32'd0;  MemWriteData_ex = 32'd0;  rdAddr_ex = 5'd0;
    RegWrite_ex = 1'b0;  MemRead_ex = 1'b0;  MemWrite_ex = 1'b0;  MemtoReg_ex = 1'b0;
    funct3_ex = 3'd0;  flush_ex = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
    idle_inputs();
    ALUResult_ex = res;  rdAddr_ex = rd;  RegWrite_ex = 1'b1;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    idle_inputs();
    ALUResult_ex = addr;  rdAddr_ex = rd;  funct3_ex = f3;
    RegWrite_ex = 1'b1;  MemRead_ex = 1'b1;  MemtoReg_ex = 1'b1;
  endtask

  // Load with 'delay' wait cycles before ack; expected writeback value is given by the caller
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                         input logic [31:0] exp);
    logic [31:0] word_addr;
    word_addr = {addr[31:2], 2'b00};
    drive_load(f3, addr, rd);
    sb_q.push_back('{rd: rd, data: exp});
    tick();
    idle_inputs();
    chk({tag, "_addr"}, dmem_addr, word_addr);
    chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, 4'b1111});
    chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd1);
      chk({tag, "_req_held"}, {31'd0, dmem_req}, 32'd1);
      tick();
      chk({tag, "_wb_bubble"}, {31'd0, RegWrite_wb}, 32'd0);
    end
    dmem_rdata = rdata;
    dmem_ack   = 1'b1;
    #1;
    chk({tag, "_nostall_on_ack"}, {31'd0, mem_stall}, 32'd0);
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
  endtask

  // Scoreboard: every retired write must match the oldest outstanding expectation
  initial begin
    wb_t e;
    forever begin
      tick();
      if (RegWrite_wb === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_wb", {27'd0, rdAddr_wb}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_wb_data", RegWriteData_wb, e.data);
          chk("sb_wb_rd", {27'd0, rdAddr_wb}, {27'd0, e.rd});
        end
      end
    end
  end

  initial begin
    idle_inputs();
    reset = 1'b1;  dmem_ack = 1'b0;  dmem_rdata = 32'd0;
    tick();
    tick();
    chk("rst_alu_mem", ALUResult_mem, 32'd0);
    chk("rst_rd_mem", {27'd0, rdAddr_mem}, 32'd0);
    chk("rst_ctl", {26'd0, RegWrite_mem, RegWrite_wb, dmem_req, dmem_we, mem_stall, misalign_mem}, 32'd0);
    chk("rst_wb_data", RegWriteData_wb, 32'd0);
    chk("rst_dmem", dmem_addr | dmem_wdata | {28'd0, dmem_be}, 32'd0);
    reset = 1'b0;

    // Plain ALU op: 2 edges from EX to WB
    drive_alu(5'd5, 32'h10);
    sb_q.push_back('{rd: 5'd5, data: 32'h10});
    tick();
    idle_inputs();
    chk("alu_rd_mem", {27'd0, rdAddr_mem}, 32'd5);
    chk("alu_regwrite_mem", {31'd0, RegWrite_mem}, 32'd1);
    chk("alu_result_mem", ALUResult_mem, 32'h10);
    chk("alu_not_wb_yet", {31'd0, RegWrite_wb}, 32'd0);
    chk("alu_no_req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("alu_regwrite_wb", {31'd0, RegWrite_wb}, 32'd1);

    // SB at 0x103 with same-cycle ack
    idle_inputs();
    ALUResult_ex = 32'h103;  MemWriteData_ex = 32'h123456AB;  MemWrite_ex = 1'b1;  funct3_ex = 3'b000;
    tick();
    idle_inputs();
    dmem_ack = 1'b1;
    #1;
    chk("sb_req", {31'd0, dmem_req}, 32'd1);
    chk("sb_we", {31'd0, dmem_we}, 32'd1);
    chk("sb_be", {28'd0, dmem_be}, {28'd0, 4'b1000});
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    chk("sb_req_done", {31'd0, dmem_req}, 32'd0);
    chk("sb_stall_after", {31'd0, mem_stall}, 32'd0);

    // SH at 0x2: upper half lanes
    idle_inputs();
    ALUResult_ex = 32'h2;  MemWriteData_ex = 32'hFFFF_BEEF;  MemWrite_ex = 1'b1;  funct3_ex = 3'b001;
    tick();
    idle_inputs();
    dmem_ack = 1'b1;
    #1;
    chk("sh_be", {28'd0, dmem_be}, {28'd0, 4'b1100});
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    tick();
    dmem_ack = 1'b0;

    // Load extraction, with and without wait cycles
    do_load("lb", 3'b000, 32'h2, 5'd7, 32'h0080_0000, 3, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h2, 5'd7, 32'h0080_0000, 3, 32'h0000_0080);
    do_load("lb_pos", 3'b000, 32'h1, 5'd8, 32'h0000_7F00, 0, 32'h0000_007F);
    do_load("lh", 3'b001, 32'h2, 5'd3, 32'h8001_0000, 1, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0, 5'd4, 32'h1234_F00F, 0, 32'h0000_F00F);

    // LW followed by add, ack one cycle late
    drive_load(3'b010, 32'h8, 5'd9);
    sb_q.push_back('{rd: 5'd9, data: 32'hDEADBEEF});
    tick();
    drive_alu(5'd10, 32'h55);
    sb_q.push_back('{rd: 5'd10, data: 32'h55});
    chk("lwadd_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    chk("lwadd_hold_alu", ALUResult_mem, 32'h8);
    chk("lwadd_hold_rd", {27'd0, rdAddr_mem}, 32'd9);
    dmem_rdata = 32'hDEADBEEF;  dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;  dmem_rdata = 32'd0;
    idle_inputs();
    chk("lwadd_load_wb_rd", {27'd0, rdAddr_wb}, 32'd9);
    chk("lwadd_add_in_mem", {27'd0, rdAddr_mem}, 32'd10);
    tick();
    chk("lwadd_add_wb_next", {26'd0, RegWrite_wb, rdAddr_wb}, {26'd0, 1'b1, 5'd10});

    // Flush ignored while stalled, then reset abandons the access in WAIT
    drive_load(3'b010, 32'h10, 5'd11);
    tick();
    idle_inputs();
    tick();
    drive_alu(5'd12, 32'h99);
    flush_ex = 1'b1;
    tick();
    chk("flush_hold_rd", {27'd0, rdAddr_mem}, 32'd11);
    chk("flush_hold_alu", ALUResult_mem, 32'h10);
    chk("flush_hold_regwrite", {31'd0, RegWrite_mem}, 32'd1);
    chk("wait_req", {31'd0, dmem_req}, 32'd1);
    idle_inputs();
    reset = 1'b1;
    tick();
    chk("wrst_req", {31'd0, dmem_req}, 32'd0);
    chk("wrst_ctl", {27'd0, RegWrite_mem, RegWrite_wb, mem_stall, misalign_mem, dmem_we}, 32'd0);
    chk("wrst_data", ALUResult_mem | RegWriteData_wb | {27'd0, rdAddr_mem} | {27'd0, rdAddr_wb}, 32'd0);
    chk("wrst_dmem", dmem_addr | dmem_wdata | {28'd0, dmem_be}, 32'd0);
    reset = 1'b0;
    drive_alu(5'd14, 32'h77);
    sb_q.push_back('{rd: 5'd14, data: 32'h77});
    tick();
    idle_inputs();
    chk("postrst_idle_req", {31'd0, dmem_req}, 32'd0);
    chk("postrst_rd_mem", {27'd0, rdAddr_mem}, 32'd14);
    tick();

    // LW at 0x6
`ifdef MEM_MISALIGN_CHECK_EN
    drive_load(3'b010, 32'h6, 5'd13);
    tick();
    idle_inputs();
    chk("mis_flag", {31'd0, misalign_mem}, 32'd1);
    chk("mis_no_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_no_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("mis_flag_1cyc", {31'd0, misalign_mem}, 32'd0);
    chk("mis_no_wb", {31'd0, RegWrite_wb}, 32'd0);
`else
    do_load("lw_unaligned", 3'b010, 32'h6, 5'd13, 32'hCAFEF00D, 0, 32'hCAFEF00D);
    chk("lw_unaligned_flag", {31'd0, misalign_mem}, 32'd0);
`endif
    tick();
    tick();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
